// File: rtl/pim_pkg.sv
// Shared constants and helpers for the PIM MAC array.
package pim_pkg;

    // FSM state encodings
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MAC  = 1'b1;

    // Saturation result: clip flag plus the clipped value (64-bit container)
    typedef struct packed {
        logic        clipped;
        logic [63:0] value;
    } sat_t;

    // Internal accumulator width: OW headroom for chained seeds plus the
    // full-precision sum of n_ch products, plus one guard bit.
    function automatic int acc_width(input int ow, input int dw, input int n_ch);
        return ow + 2 * dw + $clog2(n_ch) + 1;
    endfunction

    // Clip a signed value (at most 64 bits) to the signed range of ow bits
    function automatic sat_t sat_signed(input logic signed [63:0] acc, input int ow);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_t               r;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (acc > hi) begin
            r.clipped = 1'b1;
            r.value   = hi;
        end else if (acc < lo) begin
            r.clipped = 1'b1;
            r.value   = lo;
        end else begin
            r.clipped = 1'b0;
            r.value   = acc;
        end
        return r;
    endfunction

endpackage

// File: rtl/pim_weight_mem.sv
// Weight storage: DEPTH rows of N_CH signed words, one write port,
// one combinational word-select read port, no reset.
module pim_weight_mem #(
    parameter int N_CH  = 4,
    parameter int DW    = 6,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(DEPTH)-1:0]     waddr,
    input  logic [N_CH*DW-1:0]           wdata,
    input  logic [$clog2(DEPTH)-1:0]     raddr,
    input  logic [$clog2(N_CH)-1:0]      idx,
    output logic signed [DW-1:0]         rdata
);

    logic [N_CH*DW-1:0] mem [DEPTH];

    // Synchronous row write
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational word read from the selected row
    always_comb begin
        rdata = mem[raddr][idx*DW +: DW];
    end

endmodule

// File: rtl/pim_mac_array.sv
// Processing-in-memory MAC: sequential signed dot product of data_in with
// one stored weight row, saturated to OW bits, optionally chained.
module pim_mac_array
    import pim_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int DW    = 6,
    parameter int DEPTH = 8,
    parameter int OW    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         write,
    input  logic                         read,
    input  logic                         acc_mode,
    input  logic [$clog2(DEPTH)-1:0]     addr,
    input  logic [N_CH*DW-1:0]           data_in,
    output logic                         busy,
    output logic                         valid_out,
    output logic signed [OW-1:0]         data_out,
    output logic                         sat,
    output logic                         collide
);

    localparam int AW    = $clog2(DEPTH);
    localparam int IW    = $clog2(N_CH);
    localparam int ACC_W = acc_width(OW, DW, N_CH);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_CH - 1);

    logic [0:0]               state;
    logic [IW-1:0]            idx;
    logic [AW-1:0]            row;
    logic [N_CH*DW-1:0]       x_reg;
    logic signed [ACC_W-1:0]  acc;

    logic                     mem_we;
    logic signed [DW-1:0]     x_word;
    logic signed [DW-1:0]     w_word;
    logic signed [2*DW-1:0]   prod;
    logic signed [ACC_W-1:0]  sum;
    sat_t                     res;
    logic                     unused_hi;

    // Writes are accepted only in IDLE; a read+write collision still writes
    assign mem_we = (state == IDLE) && write;

    pim_weight_mem #(
        .N_CH  (N_CH),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (addr),
        .wdata (data_in),
        .raddr (row),
        .idx   (idx),
        .rdata (w_word)
    );

    // Current channel product and running sum including it
    always_comb begin
        x_word    = x_reg[idx*DW +: DW];
        prod      = x_word * w_word;
        sum       = acc + ACC_W'(prod);
        res       = sat_signed(64'(sum), OW);
        unused_hi = ^res.value[63:OW];
    end

    // Control FSM, channel sequencing and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            row       <= '0;
            x_reg     <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            valid_out <= 1'b0;
            data_out  <= '0;
            sat       <= 1'b0;
            collide   <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            collide   <= 1'b0;
            case (state)
                IDLE: begin
                    if (read && write) begin
                        collide <= 1'b1;
                    end else if (read) begin
                        x_reg <= data_in;
                        row   <= addr;
                        idx   <= '0;
                        acc   <= acc_mode ? ACC_W'(data_out) : '0;
                        busy  <= 1'b1;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= sum;
                    if (idx == LAST_IDX) begin
                        data_out  <= res.value[OW-1:0];
                        sat       <= res.clipped;
                        valid_out <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pim_mac_array.sv
// Directed, table-driven bench for pim_mac_array (N_CH=4, DW=6, DEPTH=8, OW=16).
module tb_pim_mac_array;

    logic               clk = 1'b0;
    logic               rst;
    logic               write;
    logic               read;
    logic               acc_mode;
    logic [2:0]         addr;
    logic [23:0]        data_in;
    logic               busy;
    logic               valid_out;
    logic signed [15:0] data_out;
    logic               sat;
    logic               collide;

    int ncmp = 0;
    int nmis = 0;

    pim_mac_array #(
        .N_CH  (4),
        .DW    (6),
        .DEPTH (8),
        .OW    (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .write     (write),
        .read      (read),
        .acc_mode  (acc_mode),
        .addr      (addr),
        .data_in   (data_in),
        .busy      (busy),
        .valid_out (valid_out),
        .data_out  (data_out),
        .sat       (sat),
        .collide   (collide)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        do_write;
        logic [2:0]  a;
        logic [23:0] wdata;
        logic [23:0] x;
        logic        mode;
        int          exp_out;
        logic        exp_sat;
    } vec_t;

    function automatic logic [23:0] pack4(input int c0, input int c1, input int c2, input int c3);
        logic [5:0] w0, w1, w2, w3;
        w0 = c0[5:0]; w1 = c1[5:0]; w2 = c2[5:0]; w3 = c3[5:0];
        return {w3, w2, w1, w0};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        ncmp++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [23:0] d);
        @(negedge clk);
        write = 1'b1; addr = a; data_in = d;
        @(negedge clk);
        write = 1'b0;
    endtask

    // Launch a read, then observe a bounded window of cycles
    task automatic run_read(input logic [2:0] a, input logic [23:0] x, input logic m,
                            output int dout, output logic s, output int bcyc, output int vcnt);
        @(negedge clk);
        read = 1'b1; addr = a; data_in = x; acc_mode = m;
        @(negedge clk);
        read = 1'b0; acc_mode = 1'b0;
        bcyc = 0; vcnt = 0; dout = -99999; s = 1'bx;
        for (int i = 0; i < 12; i++) begin
            if (busy) bcyc++;
            if (valid_out) begin
                vcnt++;
                dout = int'(data_out);
                s = sat;
            end
            @(negedge clk);
        end
    endtask

    vec_t vecs[$];

    initial begin
        int   dout, bcyc, vcnt, seen;
        logic s;

        rst = 1'b1; write = 1'b0; read = 1'b0; acc_mode = 1'b0; addr = '0; data_in = '0;

        // Test 1, 2, 3 vectors
        vecs.push_back('{1'b1, 3'd0, pack4(8, 3, -1, -7), pack4(8, 3, -1, -7), 1'b0, 123, 1'b0});
        vecs.push_back('{1'b0, 3'd0, '0, pack4(8, 3, -1, -5), 1'b0, 109, 1'b0});
        vecs.push_back('{1'b0, 3'd0, '0, pack4(8, 3, -1, -3), 1'b0, 95, 1'b0});
        vecs.push_back('{1'b0, 3'd0, '0, pack4(8, 3, -1, -1), 1'b0, 81, 1'b0});
        vecs.push_back('{1'b1, 3'd7, pack4(-32, -32, -32, -32), pack4(-32, -32, -32, -32), 1'b0, 4096, 1'b0});
        for (int k = 2; k <= 7; k++)
            vecs.push_back('{1'b0, 3'd7, '0, pack4(-32, -32, -32, -32), 1'b1, 4096 * k, 1'b0});
        vecs.push_back('{1'b0, 3'd7, '0, pack4(-32, -32, -32, -32), 1'b1, 32767, 1'b1});

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset busy", busy, 0);
        chk("reset valid_out", valid_out, 0);
        chk("reset data_out", data_out, 0);
        chk("reset sat", sat, 0);
        chk("reset collide", collide, 0);

        foreach (vecs[i]) begin
            if (vecs[i].do_write) do_write(vecs[i].a, vecs[i].wdata);
            run_read(vecs[i].a, vecs[i].x, vecs[i].mode, dout, s, bcyc, vcnt);
            chk($sformatf("vec%0d data_out", i), dout, vecs[i].exp_out);
            chk($sformatf("vec%0d sat", i), s, vecs[i].exp_sat);
            chk($sformatf("vec%0d busy cycles", i), bcyc, 4);
            chk($sformatf("vec%0d valid pulses", i), vcnt, 1);
        end

        // Test 4: read+write collision writes row2, drops the read
        @(negedge clk);
        read = 1'b1; write = 1'b1; addr = 3'd2; data_in = pack4(1, 2, 3, 4);
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        chk("collide pulse", collide, 1);
        chk("collide busy", busy, 0);
        chk("collide valid", valid_out, 0);
        @(negedge clk);
        chk("collide one cycle", collide, 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (valid_out || busy) seen++;
            @(negedge clk);
        end
        chk("collide no activity", seen, 0);
        run_read(3'd2, pack4(1, 1, 1, 1), 1'b0, dout, s, bcyc, vcnt);
        chk("row2 after collide", dout, 10);

        // Test 5: reset mid-MAC aborts, memory retained
        @(negedge clk);
        read = 1'b1; addr = 3'd0; data_in = pack4(8, 3, -1, -7);
        @(negedge clk);
        read = 1'b0;
        @(negedge clk);
        chk("pre-abort busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort data_out", data_out, 0);
        chk("abort sat", sat, 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (valid_out) seen++;
            @(negedge clk);
        end
        chk("abort no valid", seen, 0);
        run_read(3'd0, pack4(8, 3, -1, -7), 1'b0, dout, s, bcyc, vcnt);
        chk("row0 after abort", dout, 123);

        // Test 6: write/read while busy are ignored
        do_write(3'd5, pack4(1, 2, 3, 4));
        @(negedge clk);
        read = 1'b1; addr = 3'd0; data_in = pack4(8, 3, -1, -7);
        @(negedge clk);
        read = 1'b1; write = 1'b1; addr = 3'd5; data_in = pack4(9, 9, 9, 9);
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        chk("busy collide suppressed", collide, 0);
        seen = 0; vcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (valid_out) begin
                vcnt++;
                seen = int'(data_out);
            end
            @(negedge clk);
        end
        chk("busy-write read result", seen, 123);
        chk("busy-write valid pulses", vcnt, 1);
        run_read(3'd5, pack4(1, 1, 1, 1), 1'b0, dout, s, bcyc, vcnt);
        chk("row5 unchanged", dout, 10);

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nmis);
        $finish;
    end

endmodule
